// File: rtl/global_defs.sv
`default_nettype none
// ============================================================================
// Package     : global_defs
// Description : Types and widths shared by the trace parser, the request queue
//               and the DRAM command scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package global_defs;

  localparam int ADDRESS_WIDTH = 32;

  // Parsed memory operation. NOP marks a parser slot that carries no request.
  typedef enum logic [1:0] {
    NOP     = 2'd0,
    READ    = 2'd1,
    WRITE   = 2'd2,
    REFRESH = 2'd3
  } parsed_op_t;

endpackage : global_defs
`default_nettype wire

// File: rtl/request_queue.sv
`default_nettype none
// ============================================================================
// Module      : request_queue
// Description : In-order request buffer between the trace parser and the DRAM
//               command scheduler. Each rising edge of op_ready_s captures one
//               {opcode, address} into a DEPTH-entry circular buffer; the
//               oldest entry is presented on a valid/ready dequeue port along
//               with a saturating age counter.
// Revision    : 1.0 - initial release
//
// Ports
//   clk          in   single clock, all logic on posedge
//   rst_n        in   synchronous active-low reset
//   op_ready_s   in   parser strobe; a rising edge requests an enqueue
//   opcode       in   parsed op, valid while op_ready_s=1
//   address      in   parsed address, valid while op_ready_s=1
//   deq_ready    in   scheduler accepts the head entry this cycle
//   out_valid    out  head entry valid
//   out_opcode   out  head opcode
//   out_address  out  head address
//   out_age      out  cycles the head entry has waited (saturating)
//   queue_full   out  count == DEPTH
//   count        out  occupied entries
//   overflow     out  sticky: a request was dropped while full
// ============================================================================
module request_queue
  import global_defs::*;
#(
  parameter int DEPTH         = 16,
  parameter int AGE_WIDTH     = 8,
  parameter int ADDRESS_WIDTH = global_defs::ADDRESS_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         op_ready_s,
  input  parsed_op_t                   opcode,
  input  logic [ADDRESS_WIDTH-1:0]     address,
  input  logic                         deq_ready,
  output logic                         out_valid,
  output parsed_op_t                   out_opcode,
  output logic [ADDRESS_WIDTH-1:0]     out_address,
  output logic [AGE_WIDTH-1:0]         out_age,
  output logic                         queue_full,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow
);

  localparam int unsigned c_ptr_w = $clog2(DEPTH);
  localparam int unsigned c_cnt_w = $clog2(DEPTH+1);

  localparam logic [c_ptr_w-1:0]   c_ptr_one = c_ptr_w'(1);
  localparam logic [c_cnt_w-1:0]   c_cnt_one = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0]   c_depth   = c_cnt_w'(DEPTH);
  localparam logic [AGE_WIDTH-1:0] c_age_one = AGE_WIDTH'(1);
  localparam logic [AGE_WIDTH-1:0] c_age_max = {AGE_WIDTH{1'b1}};

  // --------------------------------------------------------------------------
  // Control state
  // --------------------------------------------------------------------------
  logic                 r_op_ready_q;
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_cnt_w-1:0]   r_count;
  logic                 r_overflow;

  logic                 w_push_req;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_push_acc;
  logic                 w_drop;

  // Per-entry storage, exported from the generate loop for the head mux.
  parsed_op_t             w_ent_op   [DEPTH];
  logic [ADDRESS_WIDTH-1:0] w_ent_addr [DEPTH];
  logic [AGE_WIDTH-1:0]   w_ent_age  [DEPTH];

  // Only the rising edge of the strobe requests a push; NOP slots are
  // discarded before they can affect count or overflow.
  assign w_push_req = op_ready_s & ~r_op_ready_q & (opcode != NOP);
  assign w_full     = (r_count == c_depth);
  assign w_pop      = out_valid & deq_ready;
  // A full queue still accepts when the head leaves in the same cycle: the
  // slot being vacated is exactly the one wr_ptr points at.
  assign w_push_acc = w_push_req & (~w_full | w_pop);
  assign w_drop     = w_push_req & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op_ready_q <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_op_ready_q <= op_ready_s;
      if (w_push_acc) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      if (w_push_acc && !w_pop) begin
        r_count <= r_count + c_cnt_one;
      end else if (w_pop && !w_push_acc) begin
        r_count <= r_count - c_cnt_one;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Entry storage. Occupancy is tracked by the pointers and count, so entries
  // outside the occupied window may hold stale data and age freely; a write
  // always restarts the entry's age at zero.
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    parsed_op_t               r_op;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [AGE_WIDTH-1:0]     r_age;

    always_ff @(posedge clk) begin
      if (rst_n && w_push_acc && (r_wr_ptr == c_ptr_w'(gi))) begin
        r_op   <= opcode;
        r_addr <= address;
        r_age  <= '0;
      end else if (r_age != c_age_max) begin
        r_age  <= r_age + c_age_one;
      end
    end

    assign w_ent_op[gi]   = r_op;
    assign w_ent_addr[gi] = r_addr;
    assign w_ent_age[gi]  = r_age;
  end

  // --------------------------------------------------------------------------
  // Outputs: all derived from registers only.
  // --------------------------------------------------------------------------
  assign out_valid   = (r_count != '0);
  assign out_opcode  = w_ent_op[r_rd_ptr];
  assign out_address = w_ent_addr[r_rd_ptr];
  assign out_age     = w_ent_age[r_rd_ptr];
  assign queue_full  = w_full;
  assign count       = r_count;
  assign overflow    = r_overflow;

endmodule : request_queue
`default_nettype wire

// File: tb/tb_request_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_request_queue
// Description : Directed self-checking bench for request_queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_request_queue;
  import global_defs::*;

  logic                         clk;
  logic                         rst_n;
  logic                         op_ready_s;
  parsed_op_t                   opcode;
  logic [ADDRESS_WIDTH-1:0]     address;
  logic                         deq_ready;
  logic                         out_valid;
  parsed_op_t                   out_opcode;
  logic [ADDRESS_WIDTH-1:0]     out_address;
  logic [7:0]                   out_age;
  logic                         queue_full;
  logic [4:0]                   count;
  logic                         overflow;

  int n_checks;
  int n_fail;
  logic [31:0] q_model[$];

  request_queue #(
    .DEPTH         (16),
    .AGE_WIDTH     (8),
    .ADDRESS_WIDTH (ADDRESS_WIDTH)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op_ready_s  (op_ready_s),
    .opcode      (opcode),
    .address     (address),
    .deq_ready   (deq_ready),
    .out_valid   (out_valid),
    .out_opcode  (out_opcode),
    .out_address (out_address),
    .out_age     (out_age),
    .queue_full  (queue_full),
    .count       (count),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after posedge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input parsed_op_t op, input logic [31:0] a);
    op_ready_s = 1'b1;
    opcode     = op;
    address    = a;
    step();
    op_ready_s = 1'b0;
    step();
  endtask

  // One cycle of the wrap test against a reference FIFO.
  task automatic model_cycle(input logic push, input logic [31:0] a, input logic deq);
    op_ready_s = push;
    opcode     = READ;
    address    = a;
    deq_ready  = deq;
    check_eq("wrap_valid", 64'(out_valid), 64'(q_model.size() != 0));
    if (deq && q_model.size() != 0) begin
      check_eq("wrap_order", 64'(out_address), 64'(q_model[0]));
      void'(q_model.pop_front());
    end
    step();
    if (push) q_model.push_back(a);
    check_eq("wrap_count", 64'(count), 64'(q_model.size()));
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    op_ready_s = 1'b0;
    opcode     = NOP;
    address    = '0;
    deq_ready  = 1'b0;

    // ---------------- Reset state ----------------
    repeat (2) step();
    check_eq("rst_valid", 64'(out_valid), 64'd0);
    check_eq("rst_count", 64'(count), 64'd0);
    check_eq("rst_full", 64'(queue_full), 64'd0);
    check_eq("rst_ovf", 64'(overflow), 64'd0);

    // ---------------- Single held strobe ----------------
    rst_n      = 1'b1;
    op_ready_s = 1'b1;
    opcode     = READ;
    address    = 32'h1234;
    step();
    check_eq("one_count0", 64'(count), 64'd1);
    check_eq("one_valid", 64'(out_valid), 64'd1);
    check_eq("one_age0", 64'(out_age), 64'd0);
    check_eq("one_addr", 64'(out_address), 64'h1234);
    check_eq("one_op", 64'(out_opcode), 64'(READ));
    step();
    check_eq("one_count1", 64'(count), 64'd1);
    check_eq("one_age1", 64'(out_age), 64'd1);
    step();
    check_eq("one_count2", 64'(count), 64'd1);
    check_eq("one_age2", 64'(out_age), 64'd2);
    op_ready_s = 1'b0;
    deq_ready  = 1'b1;
    step();
    check_eq("one_pop_count", 64'(count), 64'd0);
    check_eq("one_pop_valid", 64'(out_valid), 64'd0);
    deq_ready = 1'b0;

    // ---------------- Fill, overflow, drain ----------------
    for (int i = 0; i < 16; i++) strobe(READ, 32'h100 + 32'(i));
    check_eq("fill_count", 64'(count), 64'd16);
    check_eq("fill_full", 64'(queue_full), 64'd1);
    check_eq("fill_ovf", 64'(overflow), 64'd0);
    op_ready_s = 1'b1;
    opcode     = WRITE;
    address    = 32'hDEAD;
    step();
    check_eq("ovf_set", 64'(overflow), 64'd1);
    check_eq("ovf_count", 64'(count), 64'd16);
    op_ready_s = 1'b0;
    step();
    deq_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check_eq("drain_valid", 64'(out_valid), 64'd1);
      check_eq("drain_addr", 64'(out_address), 64'h100 + 64'(i));
      step();
    end
    check_eq("drain_empty", 64'(out_valid), 64'd0);
    check_eq("drain_count", 64'(count), 64'd0);
    check_eq("drain_ovf_sticky", 64'(overflow), 64'd1);
    deq_ready = 1'b0;

    // ---------------- Push and pop while full ----------------
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_eq("rst2_ovf", 64'(overflow), 64'd0);
    for (int i = 0; i < 16; i++) strobe(READ, 32'h200 + 32'(i));
    check_eq("pp_full_pre", 64'(queue_full), 64'd1);
    op_ready_s = 1'b1;
    opcode     = WRITE;
    address    = 32'h2FF;
    deq_ready  = 1'b1;
    step();
    check_eq("pp_count", 64'(count), 64'd16);
    check_eq("pp_ovf", 64'(overflow), 64'd0);
    check_eq("pp_full", 64'(queue_full), 64'd1);
    op_ready_s = 1'b0;
    for (int i = 1; i < 16; i++) begin
      check_eq("pp_drain_addr", 64'(out_address), 64'h200 + 64'(i));
      step();
    end
    check_eq("pp_last_addr", 64'(out_address), 64'h2FF);
    check_eq("pp_last_op", 64'(out_opcode), 64'(WRITE));
    step();
    check_eq("pp_empty", 64'(out_valid), 64'd0);
    deq_ready = 1'b0;

    // ---------------- Pointer wrap with random pops ----------------
    for (int i = 0; i < 40; i++) begin
      model_cycle(1'b1, 32'h300 + 32'(i),
                  (q_model.size() >= 14) ? 1'b1 : 1'($urandom_range(0, 1)));
      model_cycle(1'b0, 32'h0,
                  (q_model.size() >= 14) ? 1'b1 : 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 40; i++) begin
      if (q_model.size() != 0) model_cycle(1'b0, 32'h0, 1'b1);
    end
    check_eq("wrap_drained", 64'(count), 64'd0);
    check_eq("wrap_ovf", 64'(overflow), 64'd0);
    deq_ready = 1'b0;

    // ---------------- Age saturation ----------------
    rst_n = 1'b0;
    step();
    rst_n      = 1'b1;
    op_ready_s = 1'b1;
    opcode     = READ;
    address    = 32'h400;
    step();
    check_eq("age_0", 64'(out_age), 64'd0);
    op_ready_s = 1'b0;
    step();
    check_eq("age_1", 64'(out_age), 64'd1);
    repeat (253) step();
    check_eq("age_254", 64'(out_age), 64'd254);
    step();
    check_eq("age_255", 64'(out_age), 64'd255);
    repeat (46) step();
    check_eq("age_sat", 64'(out_age), 64'd255);
    check_eq("age_addr", 64'(out_address), 64'h400);

    // ---------------- NOP and mid-operation reset ----------------
    strobe(NOP, 32'h555);
    check_eq("nop_count", 64'(count), 64'd1);
    for (int i = 0; i < 4; i++) strobe(WRITE, 32'h500 + 32'(i));
    check_eq("five_count", 64'(count), 64'd5);
    op_ready_s = 1'b1;
    opcode     = READ;
    address    = 32'h777;
    rst_n      = 1'b0;
    step();
    check_eq("mrst_count", 64'(count), 64'd0);
    check_eq("mrst_valid", 64'(out_valid), 64'd0);
    check_eq("mrst_ovf", 64'(overflow), 64'd0);
    check_eq("mrst_full", 64'(queue_full), 64'd0);
    // Strobe still high in the first cycle after release counts as an edge.
    rst_n = 1'b1;
    step();
    check_eq("rel_count", 64'(count), 64'd1);
    check_eq("rel_addr", 64'(out_address), 64'h777);
    op_ready_s = 1'b0;
    deq_ready  = 1'b1;
    step();
    check_eq("rel_pop", 64'(count), 64'd0);
    step();
    check_eq("empty_deq_count", 64'(count), 64'd0);
    check_eq("empty_deq_valid", 64'(out_valid), 64'd0);
    deq_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_request_queue
`default_nettype wire
